mem_port_arbiter: RTL and testbench

Shares one backing-memory port between the instruction-cache refill path (requester I) and the data-cache refill/writeback path (requester D).
- Each requester issues whole-line read or write transactions.
- The arbiter grants one requester at a time, latches its transaction, drives the shared memory handshake and routes the response back to the owner.
- Sits between the I/D caches and the line-granular data memory model.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_picker.sv | 37 +++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 507 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, requester ids and default widths for the
// I/D memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_LINE_WIDTH = 128;

endpackage

// File: rtl/mem_arb_picker.sv
// mem_arb_picker: picks the winning requester for the shared memory port.
// MEM_ARB_ROUND_ROBIN_EN: ties go to the requester that was not granted last.
module mem_arb_picker
    import mem_arb_pkg::*;
(
    input  logic i_valid,
    input  logic d_valid,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        grant_valid = i_valid | d_valid;
        grant_id    = REQ_D;
        if (i_valid && d_valid) begin
            grant_id = (last_grant == REQ_I) ? REQ_D : REQ_I;
        end else if (i_valid) begin
            grant_id = REQ_I;
        end
    end
`else
    // Fixed priority has no history; the port exists so both builds share a wrapper.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant_valid = i_valid | d_valid;
        grant_id    = REQ_D;
        if (!d_valid && i_valid) begin
            grant_id = REQ_I;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one line-granular memory port between the I and D cache paths.
// Tie-break set by MEM_ARB_ROUND_ROBIN_EN (undefined: D always beats I).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LINE_WIDTH = DEF_LINE_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic                  i_req_write,
    input  logic [LINE_WIDTH-1:0] i_req_wdata,
    output logic                  i_req_ready,
    output logic                  i_resp_valid,
    input  logic                  d_req_valid,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    input  logic                  d_req_write,
    input  logic [LINE_WIDTH-1:0] d_req_wdata,
    output logic                  d_req_ready,
    output logic                  d_resp_valid,
    output logic [LINE_WIDTH-1:0] resp_rdata,
    output logic                  mem_req_valid,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_write,
    output logic [LINE_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_resp_valid,
    input  logic [LINE_WIDTH-1:0] mem_resp_rdata,
    output logic                  busy
);

    // state    | meaning
    // ST_IDLE  | no owner; arbitrate and latch the winner's request
    // ST_ISSUE | mem_req_valid held with latched fields until memory accepts
    // ST_WAIT  | waiting for mem_resp_valid
    // ST_RESP  | one-cycle resp_valid pulse to the owner

    arb_state_e            state_q;
    logic                  owner_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic [LINE_WIDTH-1:0] rdata_q;
    logic                  last_grant;
    logic                  grant_valid;
    logic                  grant_id;
    logic                  grant_now;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant_q;
    assign last_grant = last_grant_q;
`else
    assign last_grant = REQ_D;
`endif

    mem_arb_picker u_picker (
        .i_valid     (i_req_valid),
        .d_valid     (d_req_valid),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign grant_now = (state_q == ST_IDLE) && grant_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= REQ_D;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= REQ_D;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_now) begin
                        state_q <= ST_ISSUE;
                        owner_q <= grant_id;
                        if (grant_id == REQ_I) begin
                            addr_q  <= i_req_addr;
                            write_q <= i_req_write;
                            wdata_q <= i_req_wdata;
                        end else begin
                            addr_q  <= d_req_addr;
                            write_q <= d_req_write;
                            wdata_q <= d_req_wdata;
                        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_grant_q <= grant_id;
`endif
                    end
                end
                ST_ISSUE: begin
                    if (mem_ready) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        rdata_q <= mem_resp_rdata;
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Ready is decoded from live inputs, so it must also be forced low while reset is held.
    assign i_req_ready   = reset && grant_now && (grant_id == REQ_I);
    assign d_req_ready   = reset && grant_now && (grant_id == REQ_D);
    assign i_resp_valid  = (state_q == ST_RESP) && (owner_q == REQ_I);
    assign d_resp_valid  = (state_q == ST_RESP) && (owner_q == REQ_D);
    assign resp_rdata    = rdata_q;
    assign mem_req_valid = (state_q == ST_ISSUE);
    assign mem_req_addr  = addr_q;
    assign mem_req_write = write_q;
    assign mem_req_wdata = wdata_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of the I/D memory port arbiter
// against a transaction-level reference model and a line memory model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int LW = 128;
    localparam logic [LW-1:0] DEAD_LINE = 128'hDEADBEEF_00112233_44556677_8899AABB;
    localparam logic [LW-1:0] WR_LINE   = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
    localparam logic [LW-1:0] K_LINE    = 128'hCAFEF00D_13572468_ACE0BDF1_0F0F0F0F;
    localparam logic [LW-1:0] BAD_LINE  = 128'hBADBADBA_DBADBADB_ADBADBAD_BADBADBA;

    logic clk;
    logic reset;
    logic i_req_valid, i_req_write, i_req_ready, i_resp_valid;
    logic d_req_valid, d_req_write, d_req_ready, d_resp_valid;
    logic [AW-1:0] i_req_addr, d_req_addr, mem_req_addr;
    logic [LW-1:0] i_req_wdata, d_req_wdata, resp_rdata, mem_req_wdata, mem_resp_rdata;
    logic mem_req_valid, mem_req_write, mem_ready, mem_resp_valid, busy;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_write(i_req_write),
        .i_req_wdata(i_req_wdata), .i_req_ready(i_req_ready), .i_resp_valid(i_resp_valid),
        .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_write(d_req_write),
        .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready), .d_resp_valid(d_resp_valid),
        .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_write(mem_req_write),
        .mem_req_wdata(mem_req_wdata), .mem_ready(mem_ready), .mem_resp_valid(mem_resp_valid),
        .mem_resp_rdata(mem_resp_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic          write;
        logic [LW-1:0] wdata;
    } txn_t;

    typedef struct {
        int            cyc;
        logic          id;
        logic [AW-1:0] addr;
        logic          write;
        logic [LW-1:0] data;
    } ev_t;

    txn_t iq[$];
    txn_t dq[$];
    ev_t  ready_log[$];
    ev_t  resp_log[$];
    ev_t  accept_log[$];
    logic [LW-1:0] mm_mem [logic [AW-1:0]];

    int cyc, excl_err, mrv_cycles, unstable;
    logic prev_mrv, prev_write;
    logic [AW-1:0] prev_addr;
    logic [LW-1:0] prev_wdata;
    int mm_phase, mm_stall_left, mm_delay_left, mm_stall_cfg, mm_delay_cfg;
    bit mm_rand, mm_spurious;
    logic [LW-1:0] mm_rdata, mm_spur_data;
    int n_checks, n_fail;
    logic model_last;

    function automatic logic [LW-1:0] mem_default(logic [AW-1:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, a ^ 32'hC0DE_0000};
    endfunction

    function automatic txn_t mk(logic [AW-1:0] a, logic w, logic [LW-1:0] d);
        txn_t t;
        t.addr = a;
        t.write = w;
        t.wdata = d;
        return t;
    endfunction

    // Winner of a simultaneous request, from the arbitration rules alone.
    function automatic logic tie_winner(logic last);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        return (last == REQ_I) ? REQ_D : REQ_I;
`else
        return (last == last) ? REQ_D : REQ_D;
`endif
    endfunction

    task automatic mm_cfg(int stall, int delay, bit rnd);
        mm_stall_cfg  = stall;
        mm_delay_cfg  = delay;
        mm_rand       = rnd;
        mm_phase      = 0;
        mm_stall_left = rnd ? int'($urandom_range(0, 3)) : stall;
    endtask

    task automatic clear_logs();
        ready_log.delete();
        resp_log.delete();
        accept_log.delete();
        excl_err   = 0;
        mrv_cycles = 0;
        unstable   = 0;
        prev_mrv   = 1'b0;
    endtask

    // One clock cycle: drive requesters and memory, observe, then advance the memory model.
    task automatic tick();
        logic s_mrv, s_ready, s_write;
        logic [AW-1:0] s_addr;
        logic [LW-1:0] s_wdata;
        ev_t ev;
        i_req_valid = (iq.size() > 0);
        if (iq.size() > 0) begin
            i_req_addr = iq[0].addr; i_req_write = iq[0].write; i_req_wdata = iq[0].wdata;
        end
        d_req_valid = (dq.size() > 0);
        if (dq.size() > 0) begin
            d_req_addr = dq[0].addr; d_req_write = dq[0].write; d_req_wdata = dq[0].wdata;
        end
        mem_ready = 1'b0;
        mem_resp_valid = 1'b0;
        if (mm_phase == 0) begin
            mem_ready = mem_req_valid && (mm_stall_left == 0);
        end else if (mm_delay_left == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_rdata = mm_rdata;
        end
        if (mm_spurious) begin
            mem_resp_valid = 1'b1;
            mem_resp_rdata = mm_spur_data;
        end
        #1;
        if ($countones({i_req_ready, d_req_ready, i_resp_valid, d_resp_valid}) > 1) excl_err++;
        ev.cyc = cyc; ev.addr = '0; ev.write = 1'b0; ev.data = '0;
        if (i_req_ready) begin
            ev.id = REQ_I; ready_log.push_back(ev);
            if (iq.size() > 0) void'(iq.pop_front());
        end
        if (d_req_ready) begin
            ev.id = REQ_D; ready_log.push_back(ev);
            if (dq.size() > 0) void'(dq.pop_front());
        end
        ev.data = resp_rdata;
        if (i_resp_valid) begin ev.id = REQ_I; resp_log.push_back(ev); end
        if (d_resp_valid) begin ev.id = REQ_D; resp_log.push_back(ev); end
        s_mrv = mem_req_valid; s_ready = mem_ready;
        s_addr = mem_req_addr; s_write = mem_req_write; s_wdata = mem_req_wdata;
        if (s_mrv) begin
            mrv_cycles++;
            if (prev_mrv && (s_addr !== prev_addr || s_write !== prev_write || s_wdata !== prev_wdata))
                unstable++;
        end
        prev_mrv = s_mrv; prev_addr = s_addr; prev_write = s_write; prev_wdata = s_wdata;
        @(posedge clk);
        if (mm_phase == 0) begin
            if (s_mrv && s_ready) begin
                ev.cyc = cyc; ev.id = REQ_I; ev.addr = s_addr; ev.write = s_write; ev.data = s_wdata;
                accept_log.push_back(ev);
                if (s_write) begin
                    mm_mem[s_addr] = s_wdata;
                    mm_rdata = s_wdata;
                end else begin
                    mm_rdata = mm_mem.exists(s_addr) ? mm_mem[s_addr] : mem_default(s_addr);
                end
                mm_delay_left = mm_rand ? int'($urandom_range(0, 3)) : mm_delay_cfg;
                mm_phase = 1;
            end else if (s_mrv && mm_stall_left > 0) begin
                mm_stall_left--;
            end
        end else begin
            if (mm_delay_left == 0) begin
                mm_phase = 0;
                mm_stall_left = mm_rand ? int'($urandom_range(0, 3)) : mm_stall_cfg;
            end else begin
                mm_delay_left--;
            end
        end
        mm_spurious = 1'b0;
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        i_req_valid = 1'b1; i_req_addr = 32'h44; i_req_write = 1'b0; i_req_wdata = '0;
        d_req_valid = 1'b1; d_req_addr = 32'h88; d_req_write = 1'b1; d_req_wdata = WR_LINE;
        mem_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = BAD_LINE;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, mem_req_valid, mem_req_write, i_req_ready, d_req_ready, i_resp_valid, d_resp_valid} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 0000000",
                     {busy, mem_req_valid, mem_req_write, i_req_ready, d_req_ready, i_resp_valid, d_resp_valid});
        end
        n_checks++;
        if (mem_req_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h required 0", mem_req_addr); end
        n_checks++;
        if (mem_req_wdata !== '0) begin n_fail++; $display("FAIL reset_wdata: got %h required 0", mem_req_wdata); end
        n_checks++;
        if (resp_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h required 0", resp_rdata); end
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        mem_ready = 1'b0; mem_resp_valid = 1'b0;
        reset = 1'b1;
        model_last = REQ_D;
        cyc = 0;
    endtask

    task automatic test_i_read();
        int c0;
        clear_logs();
        mm_cfg(0, 0, 0);
        mm_mem[32'h40] = DEAD_LINE;
        c0 = cyc;
        iq.push_back(mk(32'h40, 1'b0, '0));
        repeat (6) tick();
        model_last = REQ_I;
        n_checks++;
        if (ready_log.size() != 1 || ready_log[0].cyc != c0 || ready_log[0].id !== REQ_I) begin
            n_fail++;
            $display("FAIL i_read_ready: got n=%0d cyc=%0d id=%0d required n=1 cyc=%0d id=0",
                     ready_log.size(), ready_log[0].cyc, ready_log[0].id, c0);
        end
        n_checks++;
        if (accept_log.size() != 1 || accept_log[0].cyc != c0 + 1 || accept_log[0].addr !== 32'h40 ||
            accept_log[0].write !== 1'b0 || mrv_cycles != 1) begin
            n_fail++;
            $display("FAIL i_read_issue: got n=%0d cyc=%0d addr=%h wr=%b mrv=%0d required n=1 cyc=%0d addr=40 wr=0 mrv=1",
                     accept_log.size(), accept_log[0].cyc, accept_log[0].addr, accept_log[0].write, mrv_cycles, c0 + 1);
        end
        n_checks++;
        if (resp_log.size() != 1 || resp_log[0].cyc != c0 + 3 || resp_log[0].id !== REQ_I) begin
            n_fail++;
            $display("FAIL i_read_resp: got n=%0d cyc=%0d id=%0d required n=1 cyc=%0d id=0",
                     resp_log.size(), resp_log[0].cyc, resp_log[0].id, c0 + 3);
        end
        n_checks++;
        if (resp_log[0].data !== DEAD_LINE) begin
            n_fail++; $display("FAIL i_read_rdata: got %h required %h", resp_log[0].data, DEAD_LINE);
        end
        n_checks++;
        if (excl_err != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL i_read_excl_busy: got excl=%0d busy=%b required 0 0", excl_err, busy);
        end
    endtask

    task automatic test_d_write_stall();
        int c0;
        clear_logs();
        mm_cfg(3, 0, 0);
        c0 = cyc;
        dq.push_back(mk(32'h100, 1'b1, WR_LINE));
        repeat (10) tick();
        model_last = REQ_D;
        n_checks++;
        if (ready_log.size() != 1 || ready_log[0].cyc != c0 || ready_log[0].id !== REQ_D) begin
            n_fail++;
            $display("FAIL d_write_ready: got n=%0d cyc=%0d id=%0d required n=1 cyc=%0d id=1",
                     ready_log.size(), ready_log[0].cyc, ready_log[0].id, c0);
        end
        n_checks++;
        if (mrv_cycles != 4 || unstable != 0) begin
            n_fail++; $display("FAIL d_write_hold: got mrv=%0d unstable=%0d required 4 0", mrv_cycles, unstable);
        end
        n_checks++;
        if (accept_log.size() != 1 || accept_log[0].cyc != c0 + 4 || accept_log[0].addr !== 32'h100 ||
            accept_log[0].write !== 1'b1 || accept_log[0].data !== WR_LINE) begin
            n_fail++;
            $display("FAIL d_write_fields: got n=%0d cyc=%0d addr=%h wr=%b wdata=%h required cyc=%0d addr=100 wr=1 wdata=%h",
                     accept_log.size(), accept_log[0].cyc, accept_log[0].addr, accept_log[0].write,
                     accept_log[0].data, c0 + 4, WR_LINE);
        end
        n_checks++;
        if (resp_log.size() != 1 || resp_log[0].cyc != c0 + 6 || resp_log[0].id !== REQ_D ||
            resp_log[0].data !== WR_LINE) begin
            n_fail++;
            $display("FAIL d_write_resp: got n=%0d cyc=%0d id=%0d data=%h required n=1 cyc=%0d id=1 data=%h",
                     resp_log.size(), resp_log[0].cyc, resp_log[0].id, resp_log[0].data, c0 + 6, WR_LINE);
        end
    endtask

    task automatic test_tie();
        int c0;
        logic first, second;
        logic [LW-1:0] exp_first, exp_second;
        for (int r = 0; r < 2; r++) begin
            clear_logs();
            mm_cfg(0, 0, 0);
            c0 = cyc;
            first  = tie_winner(model_last);
            second = ~first;
            model_last = second;
            exp_first  = (first == REQ_I) ? mem_default(32'h20) : DEAD_LINE;
            exp_second = (second == REQ_I) ? mem_default(32'h20) : DEAD_LINE;
            iq.push_back(mk(32'h20, 1'b0, '0));
            dq.push_back(mk(32'h40, 1'b0, '0));
            repeat (10) tick();
            n_checks++;
            if (ready_log.size() != 2 || ready_log[0].id !== first || ready_log[0].cyc != c0 ||
                ready_log[1].id !== second || ready_log[1].cyc != c0 + 4) begin
                n_fail++;
                $display("FAIL tie_grant_order r%0d: got n=%0d ids=%0d,%0d cycs=%0d,%0d required ids=%0d,%0d cycs=%0d,%0d",
                         r, ready_log.size(), ready_log[0].id, ready_log[1].id, ready_log[0].cyc, ready_log[1].cyc,
                         first, second, c0, c0 + 4);
            end
            n_checks++;
            if (resp_log.size() != 2 || resp_log[0].id !== first || resp_log[0].cyc != c0 + 3 ||
                resp_log[1].id !== second || resp_log[1].cyc != c0 + 7) begin
                n_fail++;
                $display("FAIL tie_resp_order r%0d: got n=%0d ids=%0d,%0d cycs=%0d,%0d required ids=%0d,%0d cycs=%0d,%0d",
                         r, resp_log.size(), resp_log[0].id, resp_log[1].id, resp_log[0].cyc, resp_log[1].cyc,
                         first, second, c0 + 3, c0 + 7);
            end
            n_checks++;
            if (resp_log[0].data !== exp_first || resp_log[1].data !== exp_second || excl_err != 0) begin
                n_fail++;
                $display("FAIL tie_rdata r%0d: got %h,%h excl=%0d required %h,%h excl=0",
                         r, resp_log[0].data, resp_log[1].data, excl_err, exp_first, exp_second);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        int guard;
        int c0;
        clear_logs();
        mm_cfg(0, 6, 0);
        dq.push_back(mk(32'h200, 1'b0, '0));
        guard = 0;
        while (accept_log.size() == 0 && guard < 10) begin
            tick();
            guard++;
        end
        n_checks++;
        if (accept_log.size() == 0) begin
            n_fail++; $display("FAIL reset_mid_reach_wait: got no memory accept within %0d cycles required 1", guard);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({busy, mem_req_valid, mem_req_write, i_req_ready, d_req_ready, i_resp_valid, d_resp_valid} !== 7'b0 ||
            mem_req_addr !== '0 || mem_req_wdata !== '0 || resp_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got flags=%b addr=%h wdata=%h rdata=%h required all 0",
                     {busy, mem_req_valid, mem_req_write, i_req_ready, d_req_ready, i_resp_valid, d_resp_valid},
                     mem_req_addr, mem_req_wdata, resp_rdata);
        end
        mm_cfg(0, 0, 0);
        repeat (3) tick();
        reset = 1'b1;
        model_last = REQ_D;
        repeat (8) tick();
        n_checks++;
        if (resp_log.size() != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_dropped: got resp=%0d busy=%b required 0 0", resp_log.size(), busy);
        end
        clear_logs();
        c0 = cyc;
        iq.push_back(mk(32'h300, 1'b0, '0));
        repeat (6) tick();
        model_last = REQ_I;
        n_checks++;
        if (resp_log.size() != 1 || resp_log[0].id !== REQ_I || resp_log[0].cyc != c0 + 3 ||
            resp_log[0].data !== mem_default(32'h300)) begin
            n_fail++;
            $display("FAIL reset_mid_fresh: got n=%0d id=%0d cyc=%0d data=%h required n=1 id=0 cyc=%0d data=%h",
                     resp_log.size(), resp_log[0].id, resp_log[0].cyc, resp_log[0].data, c0 + 3, mem_default(32'h300));
        end
    endtask

    task automatic test_spurious();
        logic [LW-1:0] held;
        held = mem_default(32'h300);
        clear_logs();
        mm_cfg(0, 0, 0);
        mm_mem[32'h80] = K_LINE;
        mm_spur_data = BAD_LINE;
        mm_spurious = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (resp_log.size() != 0 || resp_rdata !== held || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_ignored: got resp=%0d rdata=%h busy=%b required 0 %h 0",
                     resp_log.size(), resp_rdata, busy, held);
        end
        dq.push_back(mk(32'h80, 1'b0, '0));
        repeat (6) tick();
        model_last = REQ_D;
        n_checks++;
        if (resp_log.size() != 1 || resp_log[0].id !== REQ_D || resp_log[0].data !== K_LINE) begin
            n_fail++;
            $display("FAIL spurious_then_read: got n=%0d id=%0d data=%h required n=1 id=1 data=%h",
                     resp_log.size(), resp_log[0].id, resp_log[0].data, K_LINE);
        end
    endtask

    task automatic test_random();
        txn_t ilist[$], dlist[$], order[$];
        logic oid[$];
        logic [LW-1:0] exp_data[$];
        logic [LW-1:0] ref_mem [logic [AW-1:0]];
        int ni, nd, a, b, total, guard;
        logic w;
        txn_t t;
        clear_logs();
        mm_mem.delete();
        mm_cfg(0, 0, 1);
        ni = $urandom_range(3, 7);
        nd = $urandom_range(3, 7);
        for (int k = 0; k < ni + nd; k++) begin
            t = mk(32'h1000 + 32'h10 * $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   {$urandom, $urandom, $urandom, $urandom});
            if (k < ni) ilist.push_back(t); else dlist.push_back(t);
        end
        // Both requesters stay valid until their lists drain, so every grant is a tie while both remain.
        a = 0; b = 0;
        while (a < ni || b < nd) begin
            if (a < ni && b < nd) w = tie_winner(model_last);
            else w = (a < ni) ? REQ_I : REQ_D;
            model_last = w;
            if (w == REQ_I) begin order.push_back(ilist[a]); a++; end
            else begin order.push_back(dlist[b]); b++; end
            oid.push_back(w);
        end
        total = ni + nd;
        for (int k = 0; k < total; k++) begin
            if (order[k].write) begin
                exp_data.push_back(order[k].wdata);
                ref_mem[order[k].addr] = order[k].wdata;
            end else begin
                exp_data.push_back(ref_mem.exists(order[k].addr) ? ref_mem[order[k].addr] : mem_default(order[k].addr));
            end
        end
        foreach (ilist[k]) iq.push_back(ilist[k]);
        foreach (dlist[k]) dq.push_back(dlist[k]);
        guard = 0;
        while (resp_log.size() < total && guard < 600) begin
            tick();
            guard++;
        end
        repeat (2) tick();
        n_checks++;
        if (resp_log.size() != total || ready_log.size() != total || accept_log.size() != total) begin
            n_fail++;
            $display("FAIL random_counts: got resp=%0d ready=%0d accept=%0d after %0d cycles required %0d each",
                     resp_log.size(), ready_log.size(), accept_log.size(), guard, total);
        end else begin
            for (int k = 0; k < total; k++) begin
                n_checks++;
                if (ready_log[k].id !== oid[k] || resp_log[k].id !== oid[k]) begin
                    n_fail++;
                    $display("FAIL random_owner[%0d]: got ready_id=%0d resp_id=%0d required %0d",
                             k, ready_log[k].id, resp_log[k].id, oid[k]);
                end
                n_checks++;
                if (accept_log[k].addr !== order[k].addr || accept_log[k].write !== order[k].write ||
                    (order[k].write && accept_log[k].data !== order[k].wdata)) begin
                    n_fail++;
                    $display("FAIL random_mem_req[%0d]: got addr=%h wr=%b wdata=%h required addr=%h wr=%b wdata=%h",
                             k, accept_log[k].addr, accept_log[k].write, accept_log[k].data,
                             order[k].addr, order[k].write, order[k].wdata);
                end
                n_checks++;
                if (resp_log[k].data !== exp_data[k]) begin
                    n_fail++;
                    $display("FAIL random_rdata[%0d]: got %h required %h", k, resp_log[k].data, exp_data[k]);
                end
                if (k + 1 < total) begin
                    n_checks++;
                    if (ready_log[k + 1].cyc != resp_log[k].cyc + 1) begin
                        n_fail++;
                        $display("FAIL random_regrant[%0d]: got grant cyc=%0d required %0d",
                                 k, ready_log[k + 1].cyc, resp_log[k].cyc + 1);
                    end
                end
            end
        end
        n_checks++;
        if (excl_err != 0 || unstable != 0) begin
            n_fail++; $display("FAIL random_invariants: got excl=%0d unstable=%0d required 0 0", excl_err, unstable);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        mm_spurious = 1'b0;
        mm_spur_data = '0;
        mm_rdata = '0;
        i_req_addr = '0; i_req_write = 1'b0; i_req_wdata = '0;
        d_req_addr = '0; d_req_write = 1'b0; d_req_wdata = '0;
        clear_logs();
        mm_cfg(0, 0, 0);
        test_reset();
        test_i_read();
        test_d_write_stall();
        test_tie();
        test_reset_mid_wait();
        test_spurious();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
